stack_arbiter: RTL and testbench
================================

// Module: stack_arbiter
// PURPOSE
//   Shares the 32-bit CPU hardware stack between two requesters: the CPU pipeline and the
//   interrupt context-save engine (IRQ). Arbitrates push/pop requests and supports locked bursts.
//   Drives the stack's push/pop/d pins, returns pop data to the requester that issued the pop,
//   tracks occupancy and raises overflow/underflow error flags. Sits between the CPU core and Stack.
// PARAMETERS
//   DATA_W  32   width of one stack entry
//   DEPTH   128  number of stack entries; must match the Stack instance
//   CNT_W   8    occupancy counter width; must be at least clog2(DEPTH)+1
// PORTS
//   clk            in   1       system clock
//   reset          in   1       synchronous reset, active-low (0 = reset)
//   cpu_valid      in   1       CPU request valid
//   cpu_push       in   1       1 = push, 0 = pop (qualified by cpu_valid)
//   cpu_wdata      in   DATA_W  CPU push data
//   cpu_ready      out  1       CPU request accepted this cycle
//   cpu_rvalid     out  1       CPU pop data valid (1-cycle pulse)
//   cpu_rdata      out  DATA_W  CPU pop data
//   irq_valid/irq_push/irq_wdata/irq_ready/irq_rvalid/irq_rdata   same as cpu_* for the IRQ requester
//   irq_lock       in   1       IRQ holds the grant across a burst while asserted
//   stk_push       out  1       push strobe to Stack
//   stk_pop        out  1       pop strobe to Stack
//   stk_d          out  DATA_W  data to Stack
//   stk_q          in   DATA_W  Stack output; registered, valid the cycle after stk_pop
//   count          out  CNT_W   current occupancy, 0..DEPTH
//   full           out  1       count == DEPTH
//   empty          out  1       count == 0
//   err_overflow   out  1       sticky: push issued while full
//   err_underflow  out  1       sticky: pop issued while empty
//   err_clr        in   1       clears both sticky error flags
// BEHAVIOUR
//   Reset: FSM=FREE, count=0, empty=1, full=0, all ready/rvalid/strobes=0, rdata=0, errors=0.
//   At most one operation per cycle. Requests are handshakes: an op completes when valid&&ready.
//   ready is combinational from the valid inputs and the FSM state. stk_push/stk_pop/stk_d are comb.
//   FSM states:
//     FREE: IRQ has fixed priority over CPU. If irq_valid: irq_ready=1, cpu_ready=0.
//       If irq_valid&&irq_lock, go to LOCKED. Else if cpu_valid: cpu_ready=1.
//     LOCKED: only IRQ is served; cpu_ready=0. Return to FREE in the cycle irq_lock=0.
//       A request in that same cycle is still served.
//   Pop return: a 1-bit owner tag is registered at pop acceptance. Next cycle the owner's rvalid=1.
//     rdata=stk_q on that cycle; the other requester's rdata holds its last value.
//     Back-to-back pops by different owners return in issue order.
//   count: +1 on an accepted push, -1 on an accepted pop. full/empty are derived from count.
//   Boundaries:
//     Push at full: err_overflow<=1. Pop at empty: err_underflow<=1 (see CONFIGURATION).
//     err_clr and a new error in the same cycle: the flag stays set.
//     Reset mid-burst: FSM=FREE, lock dropped, pending rvalid cancelled.
// CONFIGURATION
//   STACK_ARBITER_GUARD_EN defined:
//     Push at full or pop at empty still completes the handshake (ready=1) but is dropped.
//     No stk_push/stk_pop is issued and count is unchanged.
//     A dropped pop returns rvalid=1 with rdata=0 on the next cycle.
//   STACK_ARBITER_GUARD_EN undefined:
//     The op is forwarded to Stack, so the Stack pointer wraps.
//     count saturates at DEPTH or 0. The error flag is still set.
// STRUCTURE
//   Shared package: FSM state encoding (ARB_FREE, ARB_LOCKED), owner tag constants (OWN_CPU, OWN_IRQ),
//     default DATA_W/DEPTH.
//   One sub-module, stack_occupancy: counter, full/empty, error flags, guard decision.
// TESTING
//   CPU push 0x11, 0x22 then pop x2 -> cpu_rvalid on cycles n+1: rdata 0x22 then 0x11; count 2->0.
//   cpu_valid and irq_valid together, both pushing -> irq_ready=1, cpu_ready=0; CPU is served next cycle.
//   IRQ locked burst, 4 pushes with cpu_valid held high -> cpu_ready=0 for all 4 cycles.
//     CPU is served in the cycle after irq_lock=0.
//   IRQ pop then CPU pop on consecutive cycles -> irq_rvalid then cpu_rvalid, each with correct data.
//   128 pushes -> full=1. 129th push -> err_overflow=1.
//     With GUARD_EN: count=128 and entry 0 is intact.
//     Without GUARD_EN: stk_push is issued.
//   Pop on empty with GUARD_EN -> rvalid with rdata=0, err_underflow=1; err_clr -> 0.
//   Reset asserted mid-lock -> FSM FREE, count=0, no rvalid on the following cycle.

Source files
------------

// File: rtl/stack_arbiter_pkg.sv
// Shared types and defaults for the stack arbiter: FSM encoding, pop-owner tags and
// default geometry of the CPU hardware stack.
package stack_arbiter_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int DEPTH_DEF  = 128;
    localparam int CNT_W_DEF  = 8;

    typedef enum logic {
        ARB_FREE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_t;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_IRQ = 1'b1
    } owner_t;

endpackage

// File: rtl/stack_arbiter_if.sv
// Bundle of the requester handshakes, the Stack pins and the status/error signals of
// the stack arbiter. master = environment side, slave = arbiter side.
interface stack_arbiter_if
    import stack_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
);
    logic              cpu_valid;
    logic              cpu_push;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ready;
    logic              cpu_rvalid;
    logic [DATA_W-1:0] cpu_rdata;

    logic              irq_valid;
    logic              irq_push;
    logic [DATA_W-1:0] irq_wdata;
    logic              irq_ready;
    logic              irq_rvalid;
    logic [DATA_W-1:0] irq_rdata;
    logic              irq_lock;

    logic              stk_push;
    logic              stk_pop;
    logic [DATA_W-1:0] stk_d;
    logic [DATA_W-1:0] stk_q;

    logic [CNT_W-1:0]  count;
    logic              full;
    logic              empty;
    logic              err_overflow;
    logic              err_underflow;
    logic              err_clr;

    modport master (
        output cpu_valid, cpu_push, cpu_wdata,
        output irq_valid, irq_push, irq_wdata, irq_lock,
        output stk_q, err_clr,
        input  cpu_ready, cpu_rvalid, cpu_rdata,
        input  irq_ready, irq_rvalid, irq_rdata,
        input  stk_push, stk_pop, stk_d,
        input  count, full, empty, err_overflow, err_underflow
    );

    modport slave (
        input  cpu_valid, cpu_push, cpu_wdata,
        input  irq_valid, irq_push, irq_wdata, irq_lock,
        input  stk_q, err_clr,
        output cpu_ready, cpu_rvalid, cpu_rdata,
        output irq_ready, irq_rvalid, irq_rdata,
        output stk_push, stk_pop, stk_d,
        output count, full, empty, err_overflow, err_underflow
    );

endinterface

// File: rtl/stack_occupancy.sv
// Occupancy counter, full/empty, sticky error flags and the forward/drop decision for
// accepted ops. STACK_ARBITER_GUARD_EN drops pushes at full and pops at empty.
module stack_occupancy #(
    parameter int DEPTH = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clr,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic             fwd_push,
    output logic             fwd_pop,
    output logic             drop
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic ovf;
    logic unf;

    assign full  = (count == DEPTH_C);
    assign empty = (count == '0);
    assign ovf   = push && full;
    assign unf   = pop && empty;

`ifdef STACK_ARBITER_GUARD_EN
    assign fwd_push = push && !full;
    assign fwd_pop  = pop && !empty;
    assign drop     = ovf || unf;
`else
    // Stack pointer wraps on a bad op; only the counter saturates.
    assign fwd_push = push;
    assign fwd_pop  = pop;
    assign drop     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            count         <= '0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (push && !full)
                count <= count + 1'b1;
            else if (pop && !empty)
                count <= count - 1'b1;
            // A new error wins over a simultaneous clear.
            err_overflow  <= ovf || (err_overflow && !err_clr);
            err_underflow <= unf || (err_underflow && !err_clr);
        end
    end

endmodule

// File: rtl/stack_arbiter.sv
// Shares the CPU hardware stack between the CPU pipeline and the IRQ context-save engine,
// with IRQ priority, locked IRQ bursts and pop-data return. Option: STACK_ARBITER_GUARD_EN.
module stack_arbiter
    import stack_arbiter_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic           clk,
    input  logic           reset,
    stack_arbiter_if.slave bus
);

    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              irq_acc;
    logic              cpu_acc;
    logic              acc;
    logic              op_push;
    logic [DATA_W-1:0] op_wdata;
    logic              fwd_push;
    logic              fwd_pop;
    logic              drop;
    logic              pend_valid;
    logic              pend_drop;
    owner_t            pend_owner;
    logic              cpu_ret;
    logic              irq_ret;
    logic [DATA_W-1:0] ret_data;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] irq_rdata_q;

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ARB_FREE;
        else
            state <= state_nxt;
    end

    // Nothing is granted while reset is held.
    always_comb begin
        state_nxt     = state;
        bus.cpu_ready = 1'b0;
        bus.irq_ready = 1'b0;
        if (reset) begin
            unique case (state)
                ARB_FREE: begin
                    if (bus.irq_valid) begin
                        bus.irq_ready = 1'b1;
                        if (bus.irq_lock)
                            state_nxt = ARB_LOCKED;
                    end else if (bus.cpu_valid) begin
                        bus.cpu_ready = 1'b1;
                    end
                end
                ARB_LOCKED: begin
                    bus.irq_ready = bus.irq_valid;
                    if (!bus.irq_lock)
                        state_nxt = ARB_FREE;
                end
                default: state_nxt = ARB_FREE;
            endcase
        end
    end

    assign irq_acc  = bus.irq_valid && bus.irq_ready;
    assign cpu_acc  = bus.cpu_valid && bus.cpu_ready;
    assign acc      = irq_acc || cpu_acc;
    assign op_push  = irq_acc ? bus.irq_push  : bus.cpu_push;
    assign op_wdata = irq_acc ? bus.irq_wdata : bus.cpu_wdata;

    stack_occupancy #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_occ (
        .clk           (clk),
        .reset         (reset),
        .push          (acc && op_push),
        .pop           (acc && !op_push),
        .err_clr       (bus.err_clr),
        .count         (bus.count),
        .full          (bus.full),
        .empty         (bus.empty),
        .err_overflow  (bus.err_overflow),
        .err_underflow (bus.err_underflow),
        .fwd_push      (fwd_push),
        .fwd_pop       (fwd_pop),
        .drop          (drop)
    );

    assign bus.stk_push = fwd_push;
    assign bus.stk_pop  = fwd_pop;
    assign bus.stk_d    = fwd_push ? op_wdata : '0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_valid  <= 1'b0;
            pend_drop   <= 1'b0;
            pend_owner  <= OWN_CPU;
            cpu_rdata_q <= '0;
            irq_rdata_q <= '0;
        end else begin
            pend_valid <= acc && !op_push;
            pend_drop  <= drop;
            pend_owner <= irq_acc ? OWN_IRQ : OWN_CPU;
            if (cpu_ret)
                cpu_rdata_q <= ret_data;
            if (irq_ret)
                irq_rdata_q <= ret_data;
        end
    end

    // Stack output is only valid in the return cycle, so the holding registers take it then.
    assign ret_data       = pend_drop ? '0 : bus.stk_q;
    assign cpu_ret        = reset && pend_valid && (pend_owner == OWN_CPU);
    assign irq_ret        = reset && pend_valid && (pend_owner == OWN_IRQ);
    assign bus.cpu_rvalid = cpu_ret;
    assign bus.irq_rvalid = irq_ret;
    assign bus.cpu_rdata  = cpu_ret ? ret_data : cpu_rdata_q;
    assign bus.irq_rdata  = irq_ret ? ret_data : irq_rdata_q;

endmodule

// File: tb/tb_stack_arbiter.sv
// Testbench for stack_arbiter: directed scenarios plus a randomized run checked against
// a queue-based reference model; a simple Stack model answers the stk_* pins.
module tb_stack_arbiter;
    import stack_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    stack_arbiter_if #(.DATA_W(32), .CNT_W(8)) bus ();

    stack_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stack model: registered output, valid the cycle after a pop.
    logic [31:0] stk_mem [128];
    logic [6:0]  stk_sp;
    logic [31:0] stk_qr;
    always @(posedge clk) begin
        if (!reset) stk_sp <= '0;
        else if (bus.stk_push) begin
            stk_mem[stk_sp] <= bus.stk_d;
            stk_sp          <= stk_sp + 7'd1;
        end else if (bus.stk_pop) begin
            stk_qr <= stk_mem[stk_sp - 7'd1];
            stk_sp <= stk_sp - 7'd1;
        end
    end
    assign bus.stk_q = stk_qr;

    // Reference model state
    logic        m_locked;
    logic [31:0] m_stack [$];
    logic        m_ovf, m_unf;
    logic        m_pv, m_pown, m_pknown;
    logic [31:0] m_pdata, m_crd, m_ird;

    // Expected values for the current cycle
    logic        e_cpu_ready, e_irq_ready, e_acc, e_push, e_full, e_empty, e_bad, e_fwd;
    logic        e_stk_push, e_stk_pop, e_cpu_rvalid, e_irq_rvalid;
    logic [31:0] e_d, e_cpu_rdata, e_irq_rdata;
    logic [7:0]  e_count;

    task automatic model_comb();
        int sz;
        sz      = m_stack.size();
        e_count = 8'(sz);
        e_full  = (sz == 128);
        e_empty = (sz == 0);
        if (!reset) begin
            e_irq_ready = 1'b0;
            e_cpu_ready = 1'b0;
        end else begin
            e_irq_ready = bus.irq_valid;
            e_cpu_ready = !bus.irq_valid && !m_locked && bus.cpu_valid;
        end
        e_acc  = e_irq_ready || e_cpu_ready;
        e_push = e_irq_ready ? bus.irq_push  : bus.cpu_push;
        e_d    = e_irq_ready ? bus.irq_wdata : bus.cpu_wdata;
        e_bad  = e_push ? e_full : e_empty;
`ifdef STACK_ARBITER_GUARD_EN
        e_fwd = e_acc && !e_bad;
`else
        e_fwd = e_acc;
`endif
        e_stk_push   = e_fwd && e_push;
        e_stk_pop    = e_fwd && !e_push;
        e_cpu_rvalid = reset && m_pv && !m_pown;
        e_irq_rvalid = reset && m_pv && m_pown;
        e_cpu_rdata  = e_cpu_rvalid ? m_pdata : m_crd;
        e_irq_rdata  = e_irq_rvalid ? m_pdata : m_ird;
    endtask

    task automatic commit();
        @(posedge clk);
        if (!reset) begin
            m_locked = 1'b0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            m_pv = 1'b0; m_pown = 1'b0; m_pknown = 1'b1;
            m_pdata = '0; m_crd = '0; m_ird = '0;
        end else begin
            if (e_cpu_rvalid) m_crd = m_pdata;
            if (e_irq_rvalid) m_ird = m_pdata;
            m_ovf  = (e_acc && e_push && e_full) || (m_ovf && !bus.err_clr);
            m_unf  = (e_acc && !e_push && e_empty) || (m_unf && !bus.err_clr);
            m_pv   = e_acc && !e_push;
            m_pown = e_irq_ready;
            if (e_acc && !e_push) begin
                if (!e_empty) begin
                    m_pdata  = m_stack.pop_back();
                    m_pknown = 1'b1;
                end else begin
`ifdef STACK_ARBITER_GUARD_EN
                    m_pdata  = '0;
                    m_pknown = 1'b1;
`else
                    m_pknown = 1'b0;
`endif
                end
            end
            if (e_acc && e_push && !e_full) m_stack.push_back(e_d);
            m_locked = m_locked ? bus.irq_lock : (bus.irq_valid && bus.irq_lock);
        end
    endtask

    task automatic apply(input logic rst, input logic cv, input logic cp, input logic [31:0] cd,
                         input logic iv, input logic ip, input logic [31:0] id,
                         input logic il, input logic ec);
        @(negedge clk);
        reset = rst;
        bus.cpu_valid = cv; bus.cpu_push = cp; bus.cpu_wdata = cd;
        bus.irq_valid = iv; bus.irq_push = ip; bus.irq_wdata = id;
        bus.irq_lock  = il; bus.err_clr  = ec;
        #1;
        model_comb();
    endtask

    task automatic idle();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        apply(0, 0, 0, 0, 0, 0, 0, 0, 0); commit();
    endtask

    task automatic test_reset();
        apply(0, 1, 1, 32'h5, 1, 0, 32'h6, 1, 0);
        n_checks++;
        if ({bus.cpu_ready, bus.irq_ready, bus.stk_push, bus.stk_pop} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_grants: got %b want 0000", {bus.cpu_ready, bus.irq_ready, bus.stk_push, bus.stk_pop});
        end
        commit();
        do_reset();
        idle();
        n_checks++;
        if ({bus.count, bus.full, bus.empty, bus.err_overflow, bus.err_underflow} !== {8'd0, 4'b0100}) begin
            n_fail++;
            $display("FAIL reset_status: count=%0d full=%b empty=%b ovf=%b unf=%b", bus.count, bus.full, bus.empty, bus.err_overflow, bus.err_underflow);
        end
        n_checks++;
        if ({bus.cpu_rvalid, bus.irq_rvalid, bus.cpu_rdata, bus.irq_rdata} !== 66'd0) begin
            n_fail++;
            $display("FAIL reset_return: rvalid=%b%b cpu_rdata=%h irq_rdata=%h", bus.cpu_rvalid, bus.irq_rvalid, bus.cpu_rdata, bus.irq_rdata);
        end
        commit();
    endtask

    task automatic test_lifo();
        logic [31:0] want_q [4] = '{32'h0, 32'h0, 32'h22, 32'h11};
        logic [7:0]  want_c [5] = '{8'd0, 8'd1, 8'd2, 8'd1, 8'd0};
        for (int i = 0; i < 5; i++) begin
            case (i)
                0: apply(1, 1, 1, 32'h11, 0, 0, 0, 0, 0);
                1: apply(1, 1, 1, 32'h22, 0, 0, 0, 0, 0);
                2, 3: apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
                default: idle();
            endcase
            n_checks++;
            if (bus.count !== want_c[i]) begin
                n_fail++;
                $display("FAIL lifo_count[%0d]: got %0d want %0d", i, bus.count, want_c[i]);
            end
            if (i >= 3) begin
                n_checks++;
                if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== want_q[i-1]) begin
                    n_fail++;
                    $display("FAIL lifo_pop[%0d]: rvalid=%b rdata=%h want %h", i, bus.cpu_rvalid, bus.cpu_rdata, want_q[i-1]);
                end
            end
            commit();
        end
    endtask

    task automatic test_priority();
        apply(1, 1, 1, 32'hC0, 1, 1, 32'h1A, 0, 0);
        n_checks++;
        if ({bus.irq_ready, bus.cpu_ready} !== 2'b10 || bus.stk_d !== 32'h1A) begin
            n_fail++;
            $display("FAIL prio_both: irq_ready=%b cpu_ready=%b stk_d=%h", bus.irq_ready, bus.cpu_ready, bus.stk_d);
        end
        commit();
        apply(1, 1, 1, 32'hC0, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.cpu_ready !== 1'b1 || bus.stk_d !== 32'hC0) begin
            n_fail++;
            $display("FAIL prio_cpu_next: cpu_ready=%b stk_d=%h", bus.cpu_ready, bus.stk_d);
        end
        commit();
    endtask

    task automatic test_lock_burst();
        for (int i = 0; i < 4; i++) begin
            apply(1, 1, 1, 32'hCC, 1, 1, 32'hB0 + i, 1, 0);
            n_checks++;
            if ({bus.cpu_ready, bus.irq_ready} !== 2'b01) begin
                n_fail++;
                $display("FAIL lock_burst[%0d]: cpu_ready=%b irq_ready=%b", i, bus.cpu_ready, bus.irq_ready);
            end
            commit();
        end
        apply(1, 1, 1, 32'hCC, 0, 0, 0, 1, 0);
        n_checks++;
        if (bus.cpu_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_hold_idle: cpu_ready=%b want 0", bus.cpu_ready);
        end
        commit();
        apply(1, 1, 1, 32'hCC, 1, 1, 32'hB4, 0, 0);
        n_checks++;
        if ({bus.cpu_ready, bus.irq_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL lock_release: cpu_ready=%b irq_ready=%b", bus.cpu_ready, bus.irq_ready);
        end
        commit();
        apply(1, 1, 1, 32'hCC, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.cpu_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lock_cpu_after: cpu_ready=%b want 1", bus.cpu_ready);
        end
        commit();
    endtask

    task automatic test_pop_order();
        apply(1, 1, 1, 32'hAAA1, 0, 0, 0, 0, 0); commit();
        apply(1, 1, 1, 32'hAAA2, 0, 0, 0, 0, 0); commit();
        apply(1, 0, 0, 0, 1, 0, 0, 0, 0); commit();
        apply(1, 1, 0, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if ({bus.irq_rvalid, bus.cpu_rvalid} !== 2'b10 || bus.irq_rdata !== 32'hAAA2) begin
            n_fail++;
            $display("FAIL order_irq: rvalid irq/cpu=%b%b irq_rdata=%h want AAA2", bus.irq_rvalid, bus.cpu_rvalid, bus.irq_rdata);
        end
        commit();
        idle();
        n_checks++;
        if ({bus.irq_rvalid, bus.cpu_rvalid} !== 2'b01 || bus.cpu_rdata !== 32'hAAA1 || bus.irq_rdata !== 32'hAAA2) begin
            n_fail++;
            $display("FAIL order_cpu: rvalid irq/cpu=%b%b cpu_rdata=%h irq_rdata=%h", bus.irq_rvalid, bus.cpu_rvalid, bus.cpu_rdata, bus.irq_rdata);
        end
        commit();
    endtask

    task automatic test_random();
        int sz;
        logic cv, cp, iv, ip, il;
        for (int n = 0; n < 400; n++) begin
            sz = m_stack.size();
            cv = 1'($urandom_range(0, 1));
            iv = 1'($urandom_range(0, 2) == 0);
            il = 1'($urandom_range(0, 2) == 0);
            cp = (sz == 0) ? 1'b1 : (sz == 128) ? 1'b0 : 1'($urandom_range(0, 1));
            ip = (sz == 0) ? 1'b1 : (sz == 128) ? 1'b0 : 1'($urandom_range(0, 1));
            apply(1, cv, cp, $urandom, iv, ip, $urandom, il, 1'($urandom_range(0, 7) == 0));
            n_checks++;
            if ({bus.cpu_ready, bus.irq_ready, bus.stk_push, bus.stk_pop, bus.cpu_rvalid, bus.irq_rvalid} !==
                {e_cpu_ready, e_irq_ready, e_stk_push, e_stk_pop, e_cpu_rvalid, e_irq_rvalid}) begin
                n_fail++;
                $display("FAIL rand_hs[%0d]: got %b want %b", n,
                    {bus.cpu_ready, bus.irq_ready, bus.stk_push, bus.stk_pop, bus.cpu_rvalid, bus.irq_rvalid},
                    {e_cpu_ready, e_irq_ready, e_stk_push, e_stk_pop, e_cpu_rvalid, e_irq_rvalid});
            end
            n_checks++;
            if (bus.cpu_rdata !== e_cpu_rdata || bus.irq_rdata !== e_irq_rdata || (e_stk_push && bus.stk_d !== e_d)) begin
                n_fail++;
                $display("FAIL rand_data[%0d]: cpu %h/%h irq %h/%h stk_d %h/%h", n, bus.cpu_rdata, e_cpu_rdata, bus.irq_rdata, e_irq_rdata, bus.stk_d, e_d);
            end
            n_checks++;
            if ({bus.count, bus.full, bus.empty, bus.err_overflow, bus.err_underflow} !== {e_count, e_full, e_empty, m_ovf, m_unf}) begin
                n_fail++;
                $display("FAIL rand_status[%0d]: count %0d/%0d flags %b/%b", n, bus.count, e_count,
                    {bus.full, bus.empty, bus.err_overflow, bus.err_underflow}, {e_full, e_empty, m_ovf, m_unf});
            end
            commit();
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 128; i++) begin
            apply(1, 1, 1, 32'h1000 + i, 0, 0, 0, 0, 0); commit();
        end
        apply(1, 1, 1, 32'hDEAD, 0, 0, 0, 0, 0);
        n_checks++;
        if (bus.full !== 1'b1 || bus.count !== 8'd128 || bus.err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_full: full=%b count=%0d ovf=%b", bus.full, bus.count, bus.err_overflow);
        end
        n_checks++;
`ifdef STACK_ARBITER_GUARD_EN
        if (bus.cpu_ready !== 1'b1 || bus.stk_push !== 1'b0) begin
`else
        if (bus.cpu_ready !== 1'b1 || bus.stk_push !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL ovf_push: cpu_ready=%b stk_push=%b", bus.cpu_ready, bus.stk_push);
        end
        commit();
        apply(1, 1, 1, 32'hBEEF, 0, 0, 0, 0, 1);
        n_checks++;
        if (bus.err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_flag: err_overflow=%b want 1", bus.err_overflow);
        end
        commit();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1);
        n_checks++;
        if (bus.err_overflow !== 1'b1 || bus.count !== 8'd128) begin
            n_fail++;
            $display("FAIL ovf_clr_collide: err_overflow=%b count=%0d", bus.err_overflow, bus.count);
        end
        commit();
        idle();
        n_checks++;
        if (bus.err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: err_overflow=%b want 0", bus.err_overflow);
        end
        commit();
`ifdef STACK_ARBITER_GUARD_EN
        for (int i = 0; i < 128; i++) begin
            apply(1, 1, 0, 0, 0, 0, 0, 0, 0); commit();
        end
        idle();
        n_checks++;
        if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 32'h1000 || bus.count !== 8'd0) begin
            n_fail++;
            $display("FAIL ovf_entry0: rvalid=%b rdata=%h count=%0d", bus.cpu_rvalid, bus.cpu_rdata, bus.count);
        end
        commit();
`endif
        do_reset();
    endtask

    task automatic test_underflow();
        do_reset();
        apply(1, 0, 0, 0, 1, 0, 0, 0, 0);
        n_checks++;
`ifdef STACK_ARBITER_GUARD_EN
        if (bus.irq_ready !== 1'b1 || bus.stk_pop !== 1'b0) begin
`else
        if (bus.irq_ready !== 1'b1 || bus.stk_pop !== 1'b1) begin
`endif
            n_fail++;
            $display("FAIL unf_pop: irq_ready=%b stk_pop=%b", bus.irq_ready, bus.stk_pop);
        end
        commit();
        idle();
        n_checks++;
        if (bus.irq_rvalid !== 1'b1 || bus.err_underflow !== 1'b1 || bus.count !== 8'd0) begin
            n_fail++;
            $display("FAIL unf_flag: rvalid=%b unf=%b count=%0d", bus.irq_rvalid, bus.err_underflow, bus.count);
        end
`ifdef STACK_ARBITER_GUARD_EN
        n_checks++;
        if (bus.irq_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL unf_rdata: got %h want 0", bus.irq_rdata);
        end
`endif
        commit();
        apply(1, 0, 0, 0, 0, 0, 0, 0, 1); commit();
        idle();
        n_checks++;
        if (bus.err_underflow !== 1'b0) begin
            n_fail++;
            $display("FAIL unf_clr: err_underflow=%b want 0", bus.err_underflow);
        end
        commit();
        do_reset();
    endtask

    task automatic test_reset_mid_lock();
        apply(1, 0, 0, 0, 1, 1, 32'h51, 1, 0); commit();
        apply(1, 0, 0, 0, 1, 1, 32'h52, 1, 0); commit();
        apply(1, 1, 1, 32'h9, 1, 0, 0, 1, 0); commit();
        apply(0, 1, 1, 32'h9, 1, 1, 32'h53, 1, 0);
        n_checks++;
        if ({bus.irq_rvalid, bus.irq_ready, bus.cpu_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_lock_during: irq_rvalid=%b irq_ready=%b cpu_ready=%b", bus.irq_rvalid, bus.irq_ready, bus.cpu_ready);
        end
        commit();
        apply(1, 1, 1, 32'h9, 0, 0, 0, 1, 0);
        n_checks++;
        if ({bus.irq_rvalid, bus.cpu_rvalid, bus.cpu_ready} !== 3'b001 || bus.count !== 8'd0) begin
            n_fail++;
            $display("FAIL rst_lock_after: rvalid=%b%b cpu_ready=%b count=%0d", bus.irq_rvalid, bus.cpu_rvalid, bus.cpu_ready, bus.count);
        end
        commit();
        idle(); commit();
    endtask

    initial begin
        reset = 1'b0;
        bus.cpu_valid = 0; bus.cpu_push = 0; bus.cpu_wdata = '0;
        bus.irq_valid = 0; bus.irq_push = 0; bus.irq_wdata = '0;
        bus.irq_lock  = 0; bus.err_clr  = 0;
        test_reset();
        test_lifo();
        test_priority();
        test_lock_burst();
        test_pop_order();
        test_random();
        test_overflow();
        test_underflow();
        test_reset_mid_lock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
